// File: rtl/gsr_seq_pkg.sv
// Shared definitions for the GSR/GCE startup sequencer and the flop-bank
// benches that need the same state encoding and default timing figures.
package gsr_seq_pkg;

    localparam int unsigned STATE_W = 2;

    typedef enum logic [STATE_W-1:0] {
        ST_RST      = 2'd0,
        ST_GSR_HOLD = 2'd1,
        ST_CE_WAIT  = 2'd2,
        ST_RUN      = 2'd3
    } state_t;

    localparam int unsigned DEFAULT_GSR_CYCLES = 8;
    localparam int unsigned DEFAULT_CE_DELAY   = 4;

endpackage

// File: rtl/gsr_startup_seq_reset_sync_n.sv
// Two-flop reset synchronizer: asserts asynchronously, releases on the
// second rising clock edge after rst_n goes high.
module reset_sync_n (
    input  logic clk,
    input  logic rst_n,
    output logic rst_s
);

    logic meta;

    // Shift a constant 1 through two flops once reset is released
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta  <= 1'b0;
            rst_s <= 1'b0;
        end else begin
            meta  <= 1'b1;
            rst_s <= meta;
        end
    end

endmodule

// File: rtl/gsr_startup_seq.sv
// Startup/restart sequencer driving the global set/reset (GSR) and global
// clock enable (GCE) nets for banks of async clear/preset flops.
module gsr_startup_seq
    import gsr_seq_pkg::*;
#(
    parameter int unsigned GSR_CYCLES = DEFAULT_GSR_CYCLES,
    parameter int unsigned CE_DELAY   = DEFAULT_CE_DELAY,
    parameter int unsigned CNT_W      = 8
) (
    input  logic               C,
    input  logic               CLR_N,
    input  logic               RESTART_REQ,
    output logic               RESTART_ACK,
    input  logic               FREEZE,
    output logic               GSR_OUT,
    output logic               GCE_OUT,
    output logic               DONE,
    output logic [STATE_W-1:0] STATE
);

    // A GSR_CYCLES of 0 still gives one cycle of GSR in GSR_HOLD
    localparam int unsigned      GSR_EFF  = (GSR_CYCLES == 0) ? 1 : GSR_CYCLES;
    localparam logic [CNT_W-1:0] GSR_LOAD = CNT_W'(GSR_EFF - 1);
    localparam logic [CNT_W-1:0] CE_LOAD  = (CE_DELAY == 0) ? '0 : CNT_W'(CE_DELAY - 1);

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             rst_s;

    reset_sync_n u_reset_sync (
        .clk   (C),
        .rst_n (CLR_N),
        .rst_s (rst_s)
    );

    assign STATE = state;

    // Sequencer FSM; every output is a flop updated alongside the state,
    // so entering RUN sets GCE/DONE/ACK on the same edge as the transition.
    always_ff @(posedge C or negedge CLR_N) begin
        if (!CLR_N) begin
            state       <= ST_RST;
            cnt         <= '0;
            GSR_OUT     <= 1'b1;
            GCE_OUT     <= 1'b0;
            DONE        <= 1'b0;
            RESTART_ACK <= 1'b0;
        end else begin
            case (state)
                ST_RST: begin
                    if (rst_s) begin
                        state <= ST_GSR_HOLD;
                        cnt   <= GSR_LOAD;
                    end
                end
                ST_GSR_HOLD: begin
                    if (cnt != '0) begin
                        cnt <= cnt - 1'b1;
                    end else if (CE_DELAY != 0) begin
                        state   <= ST_CE_WAIT;
                        cnt     <= CE_LOAD;
                        GSR_OUT <= 1'b0;
                    end else begin
                        state       <= ST_RUN;
                        GSR_OUT     <= 1'b0;
                        GCE_OUT     <= !FREEZE;
                        DONE        <= 1'b1;
                        RESTART_ACK <= RESTART_REQ;
                    end
                end
                ST_CE_WAIT: begin
                    if (cnt != '0) begin
                        cnt <= cnt - 1'b1;
                    end else begin
                        state       <= ST_RUN;
                        GCE_OUT     <= !FREEZE;
                        DONE        <= 1'b1;
                        RESTART_ACK <= RESTART_REQ;
                    end
                end
                ST_RUN: begin
                    // A fresh request beats FREEZE; a held request with ACK up is ignored
                    if (RESTART_REQ && !RESTART_ACK) begin
                        state   <= ST_GSR_HOLD;
                        cnt     <= GSR_LOAD;
                        GSR_OUT <= 1'b1;
                        GCE_OUT <= 1'b0;
                        DONE    <= 1'b0;
                    end else begin
                        GCE_OUT <= !FREEZE;
                        if (RESTART_ACK && !RESTART_REQ) begin
                            RESTART_ACK <= 1'b0;
                        end
                    end
                end
                default: begin
                    state   <= ST_RST;
                    GSR_OUT <= 1'b1;
                    GCE_OUT <= 1'b0;
                    DONE    <= 1'b0;
                end
            endcase
        end
    end

endmodule
